// File: rtl/dmem_ctrl.sv
// Handshaked data-memory controller for the riscv32i load/store stage.
// It decodes RV32I funct3 into size and sign, reports errors, and drives a
// word-organised synchronous-read array. A hardware sequencer fills the array
// after every reset release. A single response register decouples the
// request channel from the response channel.
module dmem_ctrl #(
  parameter int          DEPTH_WORDS     = 4096,
  parameter int          ADDR_W          = 32,
  parameter bit          INIT_PATTERN_EN = 1'b1,
  parameter logic [31:0] INIT_BASE       = 32'hFFFF0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-2:0] DEPTH_LIMIT = (ADDR_W-1)'(DEPTH_WORDS);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  init_cnt_r;
  logic              init_done_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic [1:0]        resp_err_r;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept_s;
  logic              store_s;
  logic              illegal_s;
  logic              misalign_s;
  logic              oor_s;
  logic [1:0]        err_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic [31:0]       init_val_s;
  logic [IDX_W-1:0]  idx_s;
  logic [1:0]        lane_s;
  logic [ADDR_W-3:0] word_addr_s;

  // Select and extend the loaded byte/halfword/word from a full array word.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = word >> {lane, 3'b000};
    b = shifted[7:0];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = word;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  assign req_ready   = init_done_r && (!resp_valid_r || resp_ready);
  assign accept_s    = req_valid && req_ready;
  assign idx_s       = req_addr[IDX_W+1:2];
  assign lane_s      = req_addr[1:0];
  assign word_addr_s = req_addr[ADDR_W-1:2];
  assign store_s     = accept_s && req_we && (err_s == 2'b00);
  assign init_val_s  = INIT_PATTERN_EN ? (INIT_BASE + 32'(init_cnt_r)) : 32'h00000000;

  assign resp_valid  = resp_valid_r;
  assign resp_rdata  = resp_rdata_r;
  assign resp_err    = resp_err_r;
  assign init_done   = init_done_r;

  // Classify the request; illegal outranks misaligned, which outranks out of range.
  always_comb begin
    illegal_s  = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                        : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
    misalign_s = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    oor_s      = {1'b0, word_addr_s} >= DEPTH_LIMIT;
    if (illegal_s) begin
      err_s = 2'b11;
    end else if (misalign_s) begin
      err_s = 2'b01;
    end else if (oor_s) begin
      err_s = 2'b10;
    end else begin
      err_s = 2'b00;
    end
  end

  // Build byte enables and lane-replicated store data from size and address.
  always_comb begin
    case (req_funct3[1:0])
      2'b00: begin
        be_s    = 4'b0001 << lane_s;
        wdata_s = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b1111;
        wdata_s = req_wdata;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = 32'h00000000;
      end
    endcase
  end

  // Array write port: init sequencer fill, otherwise byte-enabled stores.
  always_ff @(posedge clk) begin
    if (reset && (state_r == ST_INIT)) begin
      mem[init_cnt_r] <= init_val_s;
    end else if (reset && store_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Control FSM: init sequencing, then the single-entry response register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_INIT;
      init_cnt_r   <= '0;
      init_done_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h00000000;
      resp_err_r   <= 2'b00;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + IDX_W'(1);
          if (init_cnt_r == IDX_W'(DEPTH_WORDS - 1)) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= err_s;
            resp_rdata_r <= (req_we || (err_s != 2'b00)) ? 32'h00000000
                          : load_extract(mem[idx_s], req_funct3, lane_s);
          end else if (resp_ready) begin
            resp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random traffic,
// compared against a byte-addressed reference memory model.
module tb_dmem_ctrl;

  localparam int          DW   = 16;
  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        init_done;

  int passed = 0;
  int total  = 0;
  logic [7:0] bmem [4*DW];

  dmem_ctrl #(.DEPTH_WORDS(DW), .ADDR_W(32), .INIT_PATTERN_EN(1'b1), .INIT_BASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    logic [31:0] w;
    for (int i = 0; i < 4*DW; i++) begin
      w = BASE + 32'(i / 4);
      bmem[i] = w[8*(i%4) +: 8];
    end
  endtask

  // Expected response of one request; updates the model on a legal store.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] d, output logic [1:0] e);
    int size;
    logic [31:0] mask;
    d = 32'h0;
    e = 2'b00;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0 || (we && f3[2])) e = 2'b11;
    else if ((addr % size) != 0) e = 2'b01;
    else if (addr >= 32'(4*DW)) e = 2'b10;
    else if (we) begin
      for (int k = 0; k < size; k++) bmem[addr + k] = wd[8*k +: 8];
    end else begin
      for (int k = 0; k < size; k++) d = d | (32'(bmem[addr + k]) << (8*k));
      if (size < 4 && !f3[2]) begin
        mask = (32'h1 << (8*size)) - 32'h1;
        if (d[8*size-1]) d = d | ~mask;
      end
    end
  endtask

  // One request; response held off for 'stall' cycles. Starts and ends at a negedge.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int stall);
    logic [31:0] exp_d;
    logic [1:0]  exp_e;
    int waitc;
    model_access(we, f3, addr, wd, exp_d, exp_e);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1; resp_ready = 1'b1;
    waitc = 0;
    while (req_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    resp_ready = (stall == 0);
    check({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".rdata"}, resp_rdata, exp_d);
    check({tag, ".err"}, 32'(resp_err), 32'(exp_e));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".hold_rdata"}, resp_rdata, exp_d);
      check({tag, ".hold_err"}, 32'(resp_err), 32'(exp_e));
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.valid", 32'(resp_valid), 32'd0);
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.init_done", 32'(init_done), 32'd0);
    check("rst.rdata", resp_rdata, 32'h0);
    check("rst.err", 32'(resp_err), 32'd0);

    // Init takes exactly DW cycles after release.
    reset = 1'b1;
    for (int i = 0; i < DW; i++) begin
      check("init.ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    check("init.done", 32'(init_done), 32'd1);
    check("init.ready_high", 32'(req_ready), 32'd1);
    do_req("lw08", 1'b0, 3'b010, 32'h08, 32'h0, 0);
    check("lw08.const", resp_rdata, 32'hFFFF0002);

    // Byte store and sign/zero extended byte loads.
    do_req("sb05", 1'b1, 3'b000, 32'h05, 32'h000000AB, 0);
    do_req("lw04a", 1'b0, 3'b010, 32'h04, 32'h0, 0);
    check("lw04a.const", resp_rdata, 32'hFFFFAB01);
    do_req("lb05", 1'b0, 3'b000, 32'h05, 32'h0, 0);
    check("lb05.const", resp_rdata, 32'hFFFFFFAB);
    do_req("lbu05", 1'b0, 3'b100, 32'h05, 32'h0, 0);
    check("lbu05.const", resp_rdata, 32'h000000AB);

    // Halfword store and loads.
    do_req("sh06", 1'b1, 3'b001, 32'h06, 32'h12348001, 0);
    do_req("lh06", 1'b0, 3'b001, 32'h06, 32'h0, 0);
    check("lh06.const", resp_rdata, 32'hFFFF8001);
    do_req("lhu06", 1'b0, 3'b101, 32'h06, 32'h0, 0);
    check("lhu06.const", resp_rdata, 32'h00008001);
    do_req("lw04b", 1'b0, 3'b010, 32'h04, 32'h0, 0);
    check("lw04b.const", resp_rdata, 32'h8001AB01);

    // Error cases and priority.
    do_req("lw02", 1'b0, 3'b010, 32'h02, 32'h0, 0);
    check("lw02.err_const", 32'(resp_err), 32'd1);
    do_req("sw03", 1'b1, 3'b010, 32'h03, 32'hDEADBEEF, 0);
    check("sw03.err_const", 32'(resp_err), 32'd1);
    do_req("lw00", 1'b0, 3'b010, 32'h00, 32'h0, 0);
    check("lw00.const", resp_rdata, 32'hFFFF0000);
    do_req("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 0);
    check("lw40.err_const", 32'(resp_err), 32'd2);
    do_req("f011", 1'b0, 3'b011, 32'h00, 32'h0, 0);
    check("f011.err_const", 32'(resp_err), 32'd3);
    do_req("sh41", 1'b1, 3'b001, 32'h41, 32'h0, 0);
    check("sh41.err_const", 32'(resp_err), 32'd1);
    do_req("sb_ill", 1'b1, 3'b100, 32'h00, 32'h0, 0);

    // Backpressure, then back-to-back loads.
    do_req("lw0c_bp", 1'b0, 3'b010, 32'h0C, 32'h0, 3);
    check("lw0c.const", resp_rdata, 32'hFFFF0003);
    for (int i = 0; i < 4; i++) do_req("b2b", 1'b0, 3'b010, 32'(4*(i+8)), 32'h0, 0);

    // Random traffic, with occasional response backpressure.
    for (int n = 0; n < 200; n++) begin
      do_req("rnd", 1'(($urandom_range(0, 2)) == 0), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 4*DW + 15)), $urandom, ($urandom_range(0, 5) == 0) ? 2 : 0);
    end

    // Reset while a response is pending.
    do_req("sb05b", 1'b1, 3'b000, 32'h05, 32'h00000077, 0);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h04; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    check("mid.valid_before", 32'(resp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid.valid_dropped", 32'(resp_valid), 32'd0);
    check("mid.init_done_low", 32'(init_done), 32'd0);
    check("mid.ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    resp_ready = 1'b1;
    model_reset();
    for (int w = 0; w < 40 && init_done !== 1'b1; w++) @(negedge clk);
    check("mid.reinit_done", 32'(init_done), 32'd1);
    do_req("lw04c", 1'b0, 3'b010, 32'h04, 32'h0, 0);
    check("lw04c.const", resp_rdata, 32'hFFFF0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
